// File: rtl/data_crossbar_if.sv
// Bus bundle between the rx FIFO bank, the crossbar and the shared-data tx FIFO bank.
// The slave modport is the crossbar side; master is the FIFO-bank / environment side.
interface data_crossbar_if #(
  parameter int unsigned M  = 8,
  parameter int unsigned N  = 8,
  parameter int unsigned O  = 8,
  parameter int unsigned CW = 16
);
  logic [M*O-1:0] rx;
  logic [M-1:0]   rx_rdy;
  logic [M-1:0]   rx_pop;
  logic [N*M-1:0] lut;
  logic [N-1:0]   tx_full;
  logic [O-1:0]   tx;
  logic [N-1:0]   tx_cke;
  logic [CW-1:0]  drop_cnt;

  modport master (
    output rx, rx_rdy, lut, tx_full,
    input  rx_pop, tx, tx_cke, drop_cnt
  );

  modport slave (
    input  rx, rx_rdy, lut, tx_full,
    output rx_pop, tx, tx_cke, drop_cnt
  );
endinterface

// File: rtl/data_crossbar.sv
// M-to-N frame crossbar: work-conserving round-robin grant over rx FIFOs, multicast to tx FIFOs
// per routing LUT, with stall/drop back-pressure policy and a saturating drop counter.
module data_crossbar #(
  parameter int unsigned M     = 8,
  parameter int unsigned N     = 8,
  parameter int unsigned O     = 8,
  parameter int unsigned STALL = 1,
  parameter int unsigned CW    = 16
) (
  input logic           clk,
  input logic           rst,
  data_crossbar_if.slave bus
);

  localparam int unsigned PW = (M > 1) ? $clog2(M) : 1;
  // Sum width wide enough that base + per-grant drops cannot wrap before saturation.
  localparam int unsigned SW = CW + $clog2(N + 1) + 1;
  localparam logic [CW-1:0] DropMax = '1;

  logic [PW-1:0] r_ptr;
  logic [M-1:0]  r_pop;
  logic [O-1:0]  r_tx;
  logic [N-1:0]  r_cke;
  logic [CW-1:0] r_drop;

  logic [M-1:0]  w_elig;
  logic          w_found;
  logic [PW-1:0] w_gnt;
  int unsigned   w_idx;
  logic [N-1:0]  w_row;
  logic [N-1:0]  w_cke;
  logic [SW-1:0] w_ndrop;
  logic [SW-1:0] w_sum;
  logic [CW-1:0] w_drop_d;

  // A pending pop masks its input so the same FIFO head is never granted twice.
  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < M; i++) begin
      w_elig[i] = bus.rx_rdy[i] & ~r_pop[i];
      if (STALL != 0 && (bus.lut[i*N +: N] & bus.tx_full) != '0) begin
        w_elig[i] = 1'b0;
      end
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = 0;
    for (int unsigned k = 0; k < M; k++) begin
      w_idx = 32'(r_ptr) + k;
      if (w_idx >= M) begin
        w_idx = w_idx - M;
      end
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = PW'(w_idx);
      end
    end
  end

  always_comb begin
    w_row   = bus.lut[32'(w_gnt)*N +: N];
    w_cke   = (STALL != 0) ? w_row : (w_row & ~bus.tx_full);
    w_ndrop = '0;
    if (w_row == '0) begin
      w_ndrop = SW'(1);
    end else if (STALL == 0) begin
      w_ndrop = SW'($countones(w_row & bus.tx_full));
    end
    w_sum    = SW'(r_drop) + w_ndrop;
    w_drop_d = (w_sum > SW'(DropMax)) ? DropMax : w_sum[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= '0;
      r_pop  <= '0;
      r_tx   <= '0;
      r_cke  <= '0;
      r_drop <= '0;
    end else begin
      r_pop <= '0;
      r_cke <= '0;
      if (w_found) begin
        r_pop  <= {{(M-1){1'b0}}, 1'b1} << w_gnt;
        r_cke  <= w_cke;
        r_tx   <= bus.rx[32'(w_gnt)*O +: O];
        r_ptr  <= (w_gnt == PW'(M - 1)) ? '0 : w_gnt + 1'b1;
        r_drop <= w_drop_d;
      end
    end
  end

  assign bus.rx_pop   = r_pop;
  assign bus.tx_cke   = r_cke;
  assign bus.tx       = r_tx;
  assign bus.drop_cnt = r_drop;

endmodule

// File: tb/tb_data_crossbar.sv
// Directed bench for data_crossbar: a STALL=1/CW=16 and a STALL=0/CW=2 instance share
// routing/full stimulus; each has its own rx FIFO queues and a frame-level reference model.
module tb_data_crossbar;

  logic clk;
  logic rst;

  data_crossbar_if #(.M(4), .N(4), .O(8), .CW(16)) bus_s ();
  data_crossbar_if #(.M(4), .N(4), .O(8), .CW(2))  bus_d ();

  data_crossbar #(.M(4), .N(4), .O(8), .STALL(1), .CW(16)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s.slave)
  );
  data_crossbar #(.M(4), .N(4), .O(8), .STALL(0), .CW(2)) dut_d (
    .clk(clk), .rst(rst), .bus(bus_d.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus state: rx FIFO contents per instance/input, routing rows, tx_full.
  logic [7:0] q[2][4][$];
  logic [3:0] lut_row[4];
  logic [3:0] full;

  // Reference model state per instance (0 = stall, 1 = drop).
  int         m_ptr[2];
  logic [3:0] m_pop[2];
  logic [3:0] m_cke[2];
  logic [7:0] m_tx[2];
  int         m_drop[2];

  int  checks = 0;
  int  errors = 0;
  bit  cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_rx(input int d);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (q[d][i].size() > 0) r[i*8 +: 8] = q[d][i][0];
    end
    return r;
  endfunction

  function automatic logic [3:0] pack_rdy(input int d);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (q[d][i].size() > 0);
    return r;
  endfunction

  task automatic drive();
    logic [15:0] l;
    for (int i = 0; i < 4; i++) l[i*4 +: 4] = lut_row[i];
    bus_s.rx      = pack_rx(0);
    bus_s.rx_rdy  = pack_rdy(0);
    bus_s.lut     = l;
    bus_s.tx_full = full;
    bus_d.rx      = pack_rx(1);
    bus_d.rx_rdy  = pack_rdy(1);
    bus_d.lut     = l;
    bus_d.tx_full = full;
  endtask

  task automatic push_both(input int i, input logic [7:0] v);
    q[0][i].push_back(v);
    q[1][i].push_back(v);
  endtask

  // One arbitration edge at frame level: search from ptr with wrap, apply the policy.
  task automatic model_step(input int d);
    bit         stall;
    int         maxd;
    int         g;
    int         i;
    int         nd;
    logic [3:0] row;
    bit         ok;
    stall = (d == 0);
    maxd  = (d == 0) ? 65535 : 3;
    if (rst) begin
      m_ptr[d] = 0; m_pop[d] = '0; m_cke[d] = '0; m_tx[d] = '0; m_drop[d] = 0;
      return;
    end
    g = -1;
    for (int k = 0; k < 4; k++) begin
      i  = (m_ptr[d] + k) % 4;
      ok = (q[d][i].size() > 0) && !m_pop[d][i] && (!stall || (lut_row[i] & full) == 4'b0);
      if (g < 0 && ok) g = i;
    end
    if (g < 0) begin
      m_pop[d] = '0;
      m_cke[d] = '0;
    end else begin
      row      = lut_row[g];
      m_pop[d] = 4'b0001 << g;
      m_tx[d]  = q[d][g][0];
      m_cke[d] = stall ? row : (row & ~full);
      nd       = (row == 4'b0) ? 1 : (stall ? 0 : $countones(row & full));
      m_drop[d] = (m_drop[d] + nd > maxd) ? maxd : m_drop[d] + nd;
      m_ptr[d]  = (g + 1) % 4;
    end
  endtask

  // Edge: model samples the same inputs as the DUT, then FIFOs retire the pops that
  // were asserted during the cycle just ended.
  task automatic cycle();
    logic [3:0] old0;
    logic [3:0] old1;
    @(posedge clk);
    old0 = m_pop[0];
    old1 = m_pop[1];
    model_step(0);
    model_step(1);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (old0[i] && q[0][i].size() > 0) void'(q[0][i].pop_front());
      if (old1[i] && q[1][i].size() > 0) void'(q[1][i].pop_front());
    end
    drive();
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    drive();
    cycle();
    rst = 1'b0;
    drive();
  endtask

  // Literal expectation checked against both the DUT and the model.
  task automatic lit(input string nm, input int d, input logic [3:0] pop, input logic [3:0] cke,
                     input logic [7:0] tx, input int drop);
    if (d == 0) begin
      chk({nm, "_s_pop"}, 32'(bus_s.rx_pop), 32'(pop));
      chk({nm, "_s_cke"}, 32'(bus_s.tx_cke), 32'(cke));
      chk({nm, "_s_tx"}, 32'(bus_s.tx), 32'(tx));
      chk({nm, "_s_drop"}, 32'(bus_s.drop_cnt), 32'(drop));
    end else begin
      chk({nm, "_d_pop"}, 32'(bus_d.rx_pop), 32'(pop));
      chk({nm, "_d_cke"}, 32'(bus_d.tx_cke), 32'(cke));
      chk({nm, "_d_tx"}, 32'(bus_d.tx), 32'(tx));
      chk({nm, "_d_drop"}, 32'(bus_d.drop_cnt), 32'(drop));
    end
    chk({nm, "_model_pop"}, 32'(m_pop[d]), 32'(pop));
    chk({nm, "_model_cke"}, 32'(m_cke[d]), 32'(cke));
    chk({nm, "_model_tx"}, 32'(m_tx[d]), 32'(tx));
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_s_pop", 32'(bus_s.rx_pop), 32'(m_pop[0]));
      chk("cyc_s_cke", 32'(bus_s.tx_cke), 32'(m_cke[0]));
      chk("cyc_s_tx", 32'(bus_s.tx), 32'(m_tx[0]));
      chk("cyc_s_drop", 32'(bus_s.drop_cnt), 32'(m_drop[0]));
      chk("cyc_d_pop", 32'(bus_d.rx_pop), 32'(m_pop[1]));
      chk("cyc_d_cke", 32'(bus_d.tx_cke), 32'(m_cke[1]));
      chk("cyc_d_tx", 32'(bus_d.tx), 32'(m_tx[1]));
      chk("cyc_d_drop", 32'(bus_d.drop_cnt), 32'(m_drop[1]));
    end
  end

  initial begin
    rst  = 1'b1;
    full = 4'b0000;
    for (int i = 0; i < 4; i++) lut_row[i] = 4'b0001 << i;
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0; m_pop[d] = '0; m_cke[d] = '0; m_tx[d] = '0; m_drop[d] = 0;
    end

    // Reset held 3 cycles with every rx FIFO non-empty.
    for (int i = 0; i < 4; i++) push_both(i, 8'h10 + 8'(i));
    drive();
    for (int c = 0; c < 3; c++) begin
      cycle();
      cmp_en = 1'b1;
      lit("rst_hold", 0, 4'b0000, 4'b0000, 8'h00, 0);
      lit("rst_hold", 1, 4'b0000, 4'b0000, 8'h00, 0);
    end
    rst = 1'b0;
    drive();
    cycle();
    lit("rst_first", 0, 4'b0001, 4'b0001, 8'h10, 0);
    for (int c = 0; c < 6; c++) cycle();

    // Two active inputs alternate; per-input order preserved.
    reset_pulse();
    for (int k = 0; k < 4; k++) begin
      push_both(0, 8'h20 + 8'(k));
      push_both(2, 8'h40 + 8'(k));
    end
    drive();
    for (int k = 0; k < 8; k++) begin
      cycle();
      for (int d = 0; d < 2; d++) begin
        if (k % 2 == 0) lit("alt0", d, 4'b0001, 4'b0001, 8'h20 + 8'(k / 2), 0);
        else            lit("alt2", d, 4'b0100, 4'b0100, 8'h40 + 8'(k / 2), 0);
      end
    end
    cycle();

    // Multicast from input 0 to all outputs.
    reset_pulse();
    lut_row[0] = 4'b1111;
    push_both(0, 8'hA5);
    drive();
    cycle();
    lit("mcast", 0, 4'b0001, 4'b1111, 8'hA5, 0);
    lit("mcast", 1, 4'b0001, 4'b1111, 8'hA5, 0);
    cycle();
    lit("mcast_idle", 0, 4'b0000, 4'b0000, 8'hA5, 0);

    // Back-pressure: stall instance waits, drop instance writes the free dest and counts.
    reset_pulse();
    for (int i = 0; i < 4; i++) lut_row[i] = 4'b0001 << i;
    lut_row[1] = 4'b0011;
    full = 4'b0010;
    push_both(1, 8'h61);
    drive();
    cycle();
    lit("bp_grant", 1, 4'b0010, 4'b0001, 8'h61, 1);
    lit("bp_wait", 0, 4'b0000, 4'b0000, 8'h00, 0);
    for (int c = 0; c < 2; c++) begin
      cycle();
      lit("bp_wait", 0, 4'b0000, 4'b0000, 8'h00, 0);
    end
    full = 4'b0000;
    drive();
    cycle();
    lit("bp_release", 0, 4'b0010, 4'b0011, 8'h61, 0);
    lit("bp_after", 1, 4'b0000, 4'b0000, 8'h61, 1);
    cycle();
    lit("bp_once", 0, 4'b0000, 4'b0000, 8'h61, 0);

    // Saturation of the 2-bit counter: four more partial drops.
    full = 4'b0010;
    for (int k = 0; k < 4; k++) push_both(1, 8'h70 + 8'(k));
    drive();
    for (int c = 0; c < 8; c++) cycle();
    chk("sat_d_drop", 32'(bus_d.drop_cnt), 32'd3);
    chk("sat_model_drop", 32'(m_drop[1]), 32'd3);
    chk("sat_s_nopop", 32'(bus_s.rx_pop), 32'd0);

    // Zero row: popped and discarded, counted under both policies.
    full = 4'b0000;
    lut_row[2] = 4'b0000;
    push_both(2, 8'h88);
    drive();
    for (int c = 0; c < 12; c++) cycle();
    chk("zero_s_drop", 32'(bus_s.drop_cnt), 32'd1);
    chk("zero_d_drop", 32'(bus_d.drop_cnt), 32'd3);
    chk("zero_model_s_drop", 32'(m_drop[0]), 32'd1);

    // Reset on the edge after a grant; input 0 wins first after release.
    reset_pulse();
    for (int i = 0; i < 4; i++) lut_row[i] = 4'b0001 << i;
    push_both(0, 8'h90);
    push_both(0, 8'h91);
    for (int i = 1; i < 4; i++) push_both(i, 8'hA0 + 8'(i));
    drive();
    cycle();
    lit("r6_grant", 0, 4'b0001, 4'b0001, 8'h90, 0);
    rst = 1'b1;
    drive();
    cycle();
    lit("r6_rst", 0, 4'b0000, 4'b0000, 8'h00, 0);
    lit("r6_rst", 1, 4'b0000, 4'b0000, 8'h00, 0);
    rst = 1'b0;
    drive();
    cycle();
    lit("r6_first", 0, 4'b0001, 4'b0001, 8'h91, 0);
    lit("r6_first", 1, 4'b0001, 4'b0001, 8'h91, 0);
    for (int c = 0; c < 8; c++) cycle();

    @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
